// File: rtl/ins_sequencer.sv
// Instruction fetch/decode sequencer: 4-phase FETCH/LATCH/DECODE/UPDATE cycle
// that drives the PC strobes and offers single-byte instructions to the datapath.
module ins_sequencer #(
    parameter int ADDR_W = 8,
    parameter int INS_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] ins_address,
    input  logic [INS_W-1:0]  mem_data,
    input  logic              z_flag,
    input  logic              dp_busy,
    output logic              mem_read,
    output logic              enable,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              finish,
    output logic [INS_W-1:0]  ir,
    output logic              ir_valid,
    output logic [1:0]        phase
);
    localparam logic [INS_W-1:0] OP_END   = INS_W'(8'hFF);
    localparam logic [INS_W-1:0] OP_JMP   = INS_W'(8'hF0);
    localparam logic [INS_W-1:0] OP_JMPZ  = INS_W'(8'hF1);
    localparam logic [INS_W-1:0] OP_JMPNZ = INS_W'(8'hF2);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, DECODE, UPDATE, HALT} state_t;

    state_t state, state_n;
    logic   second_byte, second_byte_n;
    logic   enable_n;
    logic   taken;
    logic   is_end, is_jump, jump_cond;

    // The PC value is observed only for debug; the ROM address comes from the PC itself.
    logic unused_addr;
    assign unused_addr = ^ins_address;

    assign is_end    = (ir == OP_END);
    assign is_jump   = (ir == OP_JMP) || (ir == OP_JMPZ) || (ir == OP_JMPNZ);
    assign jump_cond = (ir == OP_JMP) || ((ir == OP_JMPZ) && z_flag) ||
                       ((ir == OP_JMPNZ) && !z_flag);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            second_byte <= 1'b0;
            enable      <= 1'b0;
            taken       <= 1'b0;
            ir          <= '0;
            pc_target   <= '0;
        end else begin
            state       <= state_n;
            second_byte <= second_byte_n;
            enable      <= enable_n;
            if (state == LATCH) begin
                if (second_byte) pc_target <= ADDR_W'(mem_data);
                else             ir        <= mem_data;
            end
            // Jump condition is frozen during the target-byte DECODE for use in UPDATE.
            if (state == DECODE && second_byte)
                taken <= jump_cond;
        end
    end

    always_comb begin
        state_n       = state;
        second_byte_n = second_byte;
        enable_n      = enable;
        mem_read      = 1'b0;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        finish        = 1'b0;
        ir_valid      = 1'b0;
        phase         = 2'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = FETCH;
                    enable_n = 1'b1;
                end
            end
            FETCH: begin
                mem_read = 1'b1;
                state_n  = LATCH;
            end
            LATCH: begin
                phase   = 2'd1;
                state_n = DECODE;
            end
            DECODE: begin
                phase = 2'd2;
                if (second_byte)  state_n = UPDATE;
                else if (is_end)  state_n = HALT;
                else if (is_jump) state_n = UPDATE;
                else begin
                    ir_valid = 1'b1;
                    if (!dp_busy) state_n = UPDATE;
                end
            end
            UPDATE: begin
                phase   = 2'd3;
                pc_load = second_byte && taken;
                pc_inc  = !(second_byte && taken);
                state_n = FETCH;
                // ir still holds the jump opcode while its target byte is fetched.
                second_byte_n = !second_byte && is_jump;
            end
            HALT: begin
                finish = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ins_sequencer.sv
// Bench for ins_sequencer: directed vector table plus instruction-level reference
// model that expands programs into per-cycle expected outputs.
module tb_ins_sequencer;
    logic       clk = 1'b0;
    logic       reset, start, z_flag, dp_busy;
    logic [7:0] ins_address, mem_data;
    logic       mem_read, enable, pc_inc, pc_load, finish, ir_valid;
    logic [7:0] pc_target, ir;
    logic [1:0] phase;

    ins_sequencer #(.ADDR_W(8), .INS_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .ins_address(ins_address),
        .mem_data(mem_data), .z_flag(z_flag), .dp_busy(dp_busy),
        .mem_read(mem_read), .enable(enable), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_target(pc_target), .finish(finish), .ir(ir), .ir_valid(ir_valid),
        .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mr, en, inc, ld, fin, iv;
        logic [1:0] ph;
        logic [7:0] ir, tgt;
    } outs_t;

    typedef struct {
        logic  start, busy, z;
        outs_t exp;
    } vec_t;

    // Environment: ROM with 1-cycle latency and a PC that obeys the strobes.
    logic [7:0] rom [256];
    logic [7:0] hpc, pc_init;
    always @(posedge clk) begin
        if (reset)        hpc <= pc_init;
        else if (pc_load) hpc <= pc_target;
        else if (pc_inc)  hpc <= hpc + 8'd1;
        if (mem_read) mem_data <= rom[hpc];
    end
    assign ins_address = hpc;

    int checks = 0, errors = 0;
    outs_t act;
    assign act = {mem_read, enable, pc_inc, pc_load, finish, ir_valid, phase, ir, pc_target};

    task automatic check(input outs_t e, input string nm, input int idx);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s[%0d]: got mr=%b en=%b inc=%b ld=%b fin=%b iv=%b ph=%0d ir=%h tgt=%h, want mr=%b en=%b inc=%b ld=%b fin=%b iv=%b ph=%0d ir=%h tgt=%h",
                     nm, idx, act.mr, act.en, act.inc, act.ld, act.fin, act.iv, act.ph, act.ir, act.tgt,
                     e.mr, e.en, e.inc, e.ld, e.fin, e.iv, e.ph, e.ir, e.tgt);
        end
    endtask

    function automatic vec_t mk(input logic mr, inc, ld, fin, iv, input logic [1:0] ph,
                                input logic [7:0] ir_e, tgt_e);
        vec_t v;
        v.start = 1'b0; v.busy = 1'b0; v.z = 1'b0;
        v.exp = {mr, 1'b1, inc, ld, fin, iv, ph, ir_e, tgt_e};
        return v;
    endfunction

    task automatic do_reset(input string nm);
        reset = 1'b1; start = 1'b0; dp_busy = 1'b0; z_flag = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check('0, nm, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input vec_t q[$], input string nm);
        foreach (q[i]) begin
            start = q[i].start; dp_busy = q[i].busy; z_flag = q[i].z;
            @(negedge clk);
            check(q[i].exp, nm, i);
            @(posedge clk); #1;
        end
        start = 1'b0; dp_busy = 1'b0;
    endtask

    // Reference model: walks the program one instruction at a time and emits
    // the cycles each instruction should take.
    vec_t       vq[$];
    logic [7:0] m_ir, m_tgt;
    bit         m_rnd, m_z;

    function automatic logic rb();
        return m_rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    task automatic push(input logic mr, inc, ld, fin, iv, input logic [1:0] ph, input logic busy);
        vec_t v;
        v.start = rb(); v.busy = busy; v.z = m_z;
        v.exp = {mr, 1'b1, inc, ld, fin, iv, ph, m_ir, m_tgt};
        vq.push_back(v);
    endtask

    task automatic build(input logic [7:0] pc0, input bit zc, input int stall0,
                         input bit rnd, input int max_ins);
        logic [7:0] pc, op, tgt;
        bit tk;
        int s;
        pc = pc0; m_rnd = rnd; m_ir = 8'h00; m_tgt = 8'h00; vq.delete();
        for (int n = 0; n < max_ins; n++) begin
            op  = rom[pc];
            m_z = rnd ? 1'($urandom_range(0, 1)) : zc;
            push(1, 0, 0, 0, 0, 2'd0, rb());
            push(0, 0, 0, 0, 0, 2'd1, rb());
            m_ir = op;
            if (op == 8'hFF) begin
                push(0, 0, 0, 0, 0, 2'd2, rb());
                for (int h = 0; h < 4; h++) begin
                    vec_t v;
                    v.start = rb(); v.busy = rb(); v.z = m_z;
                    v.exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, m_ir, m_tgt};
                    vq.push_back(v);
                end
                return;
            end else if (op inside {8'hF0, 8'hF1, 8'hF2}) begin
                push(0, 0, 0, 0, 0, 2'd2, rb());
                push(0, 1, 0, 0, 0, 2'd3, rb());
                pc  = pc + 8'd1;
                tgt = rom[pc];
                push(1, 0, 0, 0, 0, 2'd0, rb());
                push(0, 0, 0, 0, 0, 2'd1, rb());
                m_tgt = tgt;
                push(0, 0, 0, 0, 0, 2'd2, rb());
                tk = (op == 8'hF0) || (op == 8'hF1 && m_z) || (op == 8'hF2 && !m_z);
                push(0, !tk, tk, 0, 0, 2'd3, rb());
                pc = tk ? tgt : pc + 8'd1;
            end else begin
                s = (n == 0) ? stall0 : (rnd ? int'($urandom_range(0, 3)) : 0);
                for (int k = 0; k < s; k++) push(0, 0, 0, 0, 1, 2'd2, 1'b1);
                push(0, 0, 0, 0, 1, 2'd2, 1'b0);
                push(0, 1, 0, 0, 0, 2'd3, rb());
                pc = pc + 8'd1;
            end
        end
    endtask

    task automatic rom_fill(input logic [7:0] val);
        for (int a = 0; a < 256; a++) rom[a] = val;
    endtask

    task automatic scenario(input logic [7:0] pc0, input bit zc, input int stall0, input string nm);
        pc_init = pc0;
        do_reset({nm, "_rst"});
        build(pc0, zc, stall0, 1'b0, 20);
        do_start();
        run(vq, nm);
    endtask

    initial begin
        vec_t tbl[14];
        reset = 1'b1; start = 1'b0; dp_busy = 1'b0; z_flag = 1'b0; pc_init = 8'h00;

        // Directed: {12, 34, FF}, no stalls.
        tbl[0]  = mk(1, 0, 0, 0, 0, 2'd0, 8'h00, 8'h00);
        tbl[1]  = mk(0, 0, 0, 0, 0, 2'd1, 8'h00, 8'h00);
        tbl[2]  = mk(0, 0, 0, 0, 1, 2'd2, 8'h12, 8'h00);
        tbl[3]  = mk(0, 1, 0, 0, 0, 2'd3, 8'h12, 8'h00);
        tbl[4]  = mk(1, 0, 0, 0, 0, 2'd0, 8'h12, 8'h00);
        tbl[5]  = mk(0, 0, 0, 0, 0, 2'd1, 8'h12, 8'h00);
        tbl[6]  = mk(0, 0, 0, 0, 1, 2'd2, 8'h34, 8'h00);
        tbl[7]  = mk(0, 1, 0, 0, 0, 2'd3, 8'h34, 8'h00);
        tbl[8]  = mk(1, 0, 0, 0, 0, 2'd0, 8'h34, 8'h00);
        tbl[9]  = mk(0, 0, 0, 0, 0, 2'd1, 8'h34, 8'h00);
        tbl[10] = mk(0, 0, 0, 0, 0, 2'd2, 8'hFF, 8'h00);
        tbl[11] = mk(0, 0, 0, 1, 0, 2'd0, 8'hFF, 8'h00);
        tbl[12] = mk(0, 0, 0, 1, 0, 2'd0, 8'hFF, 8'h00);
        tbl[13] = mk(0, 0, 0, 1, 0, 2'd0, 8'hFF, 8'h00);
        tbl[12].start = 1'b1;
        rom_fill(8'hFF);
        rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'hFF;
        do_reset("reset0");
        do_start();
        foreach (tbl[i]) vq.push_back(tbl[i]);
        run(vq, "table");
        vq.delete();

        // Reset out of HALT.
        do_reset("halt_rst");

        // Stall of 3 cycles on the first instruction.
        rom_fill(8'hFF); rom[0] = 8'h12;
        scenario(8'h00, 1'b0, 3, "stall");

        // JMP to 40.
        rom_fill(8'hFF); rom[0] = 8'hF0; rom[1] = 8'h40;
        scenario(8'h00, 1'b0, 0, "jmp");

        // JMPZ not taken / taken.
        rom_fill(8'hFF); rom[0] = 8'hF1; rom[1] = 8'h10; rom[2] = 8'h21; rom[8'h10] = 8'h5A;
        scenario(8'h00, 1'b0, 0, "jmpz0");
        scenario(8'h00, 1'b1, 0, "jmpz1");

        // JMPNZ at FF reads its target from 00.
        rom_fill(8'hFF); rom[8'hFF] = 8'hF2; rom[8'h00] = 8'h55; rom[8'h55] = 8'h07;
        scenario(8'hFF, 1'b0, 0, "jmpnz_wrap");

        // Reset in LATCH, then restart.
        rom_fill(8'hFF); rom[0] = 8'h77; pc_init = 8'h00;
        do_reset("latch_pre");
        do_start();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check('0, "latch_rst", 0);
        @(posedge clk); #1;
        build(8'h00, 1'b0, 1, 1'b0, 20);
        do_start();
        run(vq, "restart");

        // Random programs with random stalls, z_flag and stray start/dp_busy.
        for (int p = 0; p < 12; p++) begin
            for (int a = 0; a < 256; a++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 4)       rom[a] = 8'hFF;
                else if (r < 22) rom[a] = 8'hF0 + 8'($urandom_range(0, 2));
                else             rom[a] = 8'($urandom_range(0, 8'hEF));
            end
            pc_init = 8'($urandom_range(0, 255));
            do_reset("rnd_rst");
            build(pc_init, 1'b0, int'($urandom_range(0, 3)), 1'b1, 30);
            do_start();
            run(vq, $sformatf("rnd%0d", p));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
